// File: rtl/multi_channel_debouncer.sv
// Multi-channel input debouncer: two-flop synchroniser, per-channel stability
// counter, clean level, registered rise/fall pulses and optional sticky latch.
module multi_channel_debouncer #(
  parameter int                  CHANNELS      = 4,
  parameter int                  STABLE_CYCLES = 16,
  parameter logic [CHANNELS-1:0] RESET_VALUE   = '0,
  parameter logic [CHANNELS-1:0] LATCH_MASK    = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] latched
);

  localparam int             CW       = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]  TERMINAL = CW'(STABLE_CYCLES - 1);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic          s1;
      logic          s2;
      logic          level;
      logic          rise_q;
      logic          fall_q;
      logic [CW-1:0] cnt;
      logic          done;

      // The new value has held long enough: clean follows s2 on this edge.
      assign done = (s2 != level) && (cnt == TERMINAL);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1     <= RESET_VALUE[gi];
          s2     <= RESET_VALUE[gi];
          level  <= RESET_VALUE[gi];
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          cnt    <= '0;
        end else begin
          s1     <= noisy[gi];
          s2     <= s1;
          rise_q <= done && s2;
          fall_q <= done && !s2;
          if (s2 == level) begin
            cnt <= '0;
          end else if (cnt == TERMINAL) begin
            level <= s2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign clean[gi] = level;
      assign rise[gi]  = rise_q;
      assign fall[gi]  = fall_q;

      if (LATCH_MASK[gi]) begin : g_latch
        logic flag;
        // Set has priority over a coincident clear so no request is lost.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            flag <= 1'b0;
          end else if (done && s2) begin
            flag <= 1'b1;
          end else if (clear[gi]) begin
            flag <= 1'b0;
          end
        end
        assign latched[gi] = flag;
      end else begin : g_no_latch
        logic unused_clear;
        assign unused_clear = clear[gi];
        assign latched[gi]  = 1'b0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Scoreboard bench for multi_channel_debouncer: expected pulse events are
// queued by the stimulus and checked by a monitor whenever rise/fall fire.
module tb_multi_channel_debouncer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] noisy = 4'b0000;
  logic [3:0] clear = 4'b0000;
  logic [3:0] clean, rise, fall, latched;

  logic [3:0] noisy1 = 4'b0001;
  logic [3:0] clear1 = 4'b0000;
  logic [3:0] clean1, rise1, fall1, latched1;

  int edge_cnt = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         edge_no;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] clean;
    logic [3:0] latched;
  } ev_t;
  ev_t exp_q[$];

  multi_channel_debouncer #(
    .CHANNELS(4), .STABLE_CYCLES(4), .RESET_VALUE(4'b0000), .LATCH_MASK(4'b0100)
  ) dut (
    .clk(clk), .reset(reset), .noisy(noisy), .clear(clear),
    .clean(clean), .rise(rise), .fall(fall), .latched(latched)
  );

  multi_channel_debouncer #(
    .CHANNELS(4), .STABLE_CYCLES(4), .RESET_VALUE(4'b0001), .LATCH_MASK(4'b0100)
  ) dut_rv (
    .clk(clk), .reset(reset), .noisy(noisy1), .clear(clear1),
    .clean(clean1), .rise(rise1), .fall(fall1), .latched(latched1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int e, input logic [3:0] r, input logic [3:0] f,
                      input logic [3:0] c, input logic [3:0] l);
    ev_t ev;
    ev.edge_no = e; ev.rise = r; ev.fall = f; ev.clean = c; ev.latched = l;
    exp_q.push_back(ev);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  // Monitor: every pulse on the main DUT must match the next queued event.
  always @(negedge clk) begin
    if (!reset && (rise | fall) != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: edge %0d rise %b fall %b, no event expected",
                 edge_cnt, rise, fall);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        if (ev.edge_no != edge_cnt || ev.rise !== rise || ev.fall !== fall ||
            ev.clean !== clean || ev.latched !== latched) begin
          errors++;
          $display("FAIL event: got edge %0d rise %b fall %b clean %b latched %b, expected edge %0d rise %b fall %b clean %b latched %b",
                   edge_cnt, rise, fall, clean, latched,
                   ev.edge_no, ev.rise, ev.fall, ev.clean, ev.latched);
        end else begin
          $display("ok   event: edge %0d rise %b fall %b clean %b latched %b",
                   edge_cnt, rise, fall, clean, latched);
        end
      end
    end
    if (!reset && (rise1 | fall1) != 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL rv_pulse: rise %b fall %b, expected none", rise1, fall1);
    end
  end

  initial begin
    step(3);
    check("reset_clean", clean, 4'b0000);
    check("reset_rise", rise, 4'b0000);
    check("reset_fall", fall, 4'b0000);
    check("reset_latched", latched, 4'b0000);
    check("rv_reset_clean", clean1, 4'b0001);
    reset = 1'b0;
    step(2);

    // Glitch of three cycles on channel 1
    noisy[1] = 1'b1;
    step(3);
    noisy[1] = 1'b0;
    step(8);
    check("glitch_clean", clean, 4'b0000);

    // Clean rise and fall on channel 0
    noisy[0] = 1'b1;
    push(edge_cnt + 6, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    step(10);
    check("ch0_high", clean, 4'b0001);
    noisy[0] = 1'b0;
    push(edge_cnt + 6, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(10);
    check("ch0_low", clean, 4'b0000);

    // Sticky latch on channel 2
    noisy[2] = 1'b1;
    push(edge_cnt + 6, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    step(8);
    check("latch_set", latched, 4'b0100);
    noisy[2] = 1'b0;
    push(edge_cnt + 6, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
    step(8);
    check("latch_after_fall", latched, 4'b0100);
    clear[2] = 1'b1;
    step(1);
    clear[2] = 1'b0;
    check("latch_clear", latched, 4'b0000);

    // Clear coincident with the setting edge: set wins
    noisy[2] = 1'b1;
    push(edge_cnt + 6, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    step(5);
    clear[2] = 1'b1;
    step(1);
    clear[2] = 1'b0;
    check("set_wins", latched, 4'b0100);
    noisy[2] = 1'b0;
    push(edge_cnt + 6, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
    step(8);
    clear[2] = 1'b1;
    step(1);
    clear[2] = 1'b0;
    check("latch_clear2", latched, 4'b0000);

    // Simultaneous channels, unmasked latches ignore clear
    noisy = 4'b1011;
    push(edge_cnt + 6, 4'b1011, 4'b0000, 4'b1011, 4'b0000);
    step(8);
    check("unmasked_before", latched, 4'b0000);
    clear = 4'hF;
    step(1);
    clear = 4'h0;
    check("unmasked_after", latched, 4'b0000);
    check("simul_clean", clean, 4'b1011);
    noisy = 4'b0100;
    push(edge_cnt + 6, 4'b0100, 4'b1011, 4'b0100, 4'b0100);
    step(8);

    // Reset asynchronously while channel 3 counts at 2
    noisy = 4'b1100;
    step(4);
    #2 reset = 1'b1;
    #1;
    check("async_clean", clean, 4'b0000);
    check("async_rise", rise, 4'b0000);
    check("async_fall", fall, 4'b0000);
    check("async_latched", latched, 4'b0000);
    step(2);
    reset = 1'b0;
    push(edge_cnt + 6, 4'b1100, 4'b0000, 4'b1100, 4'b0100);
    step(5);
    check("post_reset_early", clean, 4'b0000);
    step(3);
    check("post_reset_clean", clean, 4'b1100);

    noisy = 4'b0000;
    push(edge_cnt + 6, 4'b0000, 4'b1100, 4'b0000, 4'b0100);
    step(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_empty: %0d events pending, expected 0", exp_q.size());
    end else begin
      $display("ok   queue_empty");
    end
    check("rv_clean_end", clean1, 4'b0001);
    check("rv_latched_end", latched1, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
